icache_controller: RTL

- Direct-mapped instruction cache between the program counter and the block-oriented instruction memory.
- Takes the fetch address from the PC and returns the 32-bit instruction.
- Drives the `busywait` signal that stalls the PC on a miss.
- Fills 16-byte (4-word) blocks from instruction memory through a `mem_read`/`mem_busywait` handshake.

---
 rtl/icache_controller_if.sv | 38 +++
 rtl/icache_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/icache_controller_if.sv
// Bus bundle for the instruction cache. It groups the fetch-side signals
// (pc_address, instruction, busywait) and the memory-side signals
// (mem_read, mem_address, mem_readdata, mem_busywait).
//   slave  : the cache's view. It takes the fetch address and the memory
//            response, and drives the instruction, the stall and the
//            memory request.
//   master : the environment's view (PC plus instruction memory).
interface icache_controller_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] pc_address;
  logic [31:0]       instruction;
  logic              busywait;
  logic              mem_read;
  logic [ADDR_W-5:0] mem_address;
  logic [127:0]      mem_readdata;
  logic              mem_busywait;

  modport master (
    output pc_address,
    output mem_readdata,
    output mem_busywait,
    input  instruction,
    input  busywait,
    input  mem_read,
    input  mem_address
  );

  modport slave (
    input  pc_address,
    input  mem_readdata,
    input  mem_busywait,
    output instruction,
    output busywait,
    output mem_read,
    output mem_address
  );
endinterface

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache. It sits between the PC and a
// block-oriented instruction memory that returns 16-byte (4-word) blocks.
//
// Ports:
//   CLK        : system clock; all state updates on the rising edge.
//   RESET      : asynchronous, active-low reset. It clears the valid bits and
//                the FSM, and forces busywait and mem_read low.
//   bus        : icache_controller_if.slave
//                pc_address / instruction / busywait connect to the PC;
//                mem_read / mem_address / mem_readdata / mem_busywait
//                connect to the instruction memory.
//   hit_count, miss_count : present only when ICACHE_STATS_EN is defined.
//
// Optional feature macro: ICACHE_STATS_EN (adds the hit/miss counters).
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | serving hits combinationally; a miss stalls the PC and requests a fill
// MEM_READ | block request outstanding; wait for mem_busywait to fall
module icache_controller #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  icache_controller_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int TAG_W  = ADDR_W - 4 - INDEX_W;
  localparam int NLINES = 1 << INDEX_W;

  typedef enum logic {
    S_IDLE,
    S_MEM_READ
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Set once the memory's sampling edge has passed. mem_busywait is not
  // meaningful until then.
  logic r_sampled;

  logic [NLINES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [NLINES];
  logic [127:0]      r_data [NLINES];

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_word;
  logic [1:0]         w_unused_offset;
  logic [127:0]       w_line;
  logic               w_hit;
  logic               w_fill;
  logic               w_busywait;
  logic               w_mem_read;

  assign w_unused_offset = bus.pc_address[1:0];
  assign w_word          = bus.pc_address[3:2];
  assign w_index         = bus.pc_address[3+INDEX_W:4];
  assign w_tag           = bus.pc_address[ADDR_W-1:4+INDEX_W];

  assign w_line = r_data[w_index];
  assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign bus.instruction = w_line[{w_word, 5'b00000} +: 32];
  assign bus.mem_address = bus.pc_address[ADDR_W-1:4];

  // Gate the outputs with RESET so they drop as soon as reset asserts. This
  // matters for busywait: with every line invalid, IDLE would otherwise
  // report a miss.
  assign bus.busywait = w_busywait & RESET;
  assign bus.mem_read = w_mem_read & RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_sampled <= 1'b0;
      r_valid   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // Low on the IDLE->MEM_READ edge, high from the first MEM_READ edge on.
      r_sampled <= (r_state == S_MEM_READ);
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
      end
    end
  end

  // Tags and data are not reset. Only the valid bits carry meaning after
  // reset. While reset is held the FSM stays in IDLE, so w_fill stays low
  // and a fill that was in progress is dropped.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= bus.mem_readdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busywait  = 1'b0;
    w_mem_read  = 1'b0;
    w_fill      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busywait = !w_hit;
        if (!w_hit) begin
          w_state_nxt = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        w_busywait = 1'b1;
        w_mem_read = 1'b1;
        if (r_sampled && !bus.mem_busywait) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end else begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule
